reduce_32bit: RTL and testbench

REDUCE_32BIT -- requirements
Module: reduce_32bit

---
 rtl/reduce_32bit.sv | 101 ++++++++++
 tb/tb_reduce_32bit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reduce_32bit.sv
// reduce_32bit: multi-cycle OR/NOR reduction and highest-set-bit search over a
// captured 32-bit word. The search examines STEP bits per cycle from bit 31
// downward and always runs the full 32/STEP cycles, so latency is independent
// of the data.
module reduce_32bit #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in,
  output logic        busy,
  output logic        done,
  output logic        nonzero,
  output logic        zero,
  output logic [4:0]  msb_index
);

  localparam int N  = 32 / STEP;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [31:0]     cap;
  logic            found;
  logic [4:0]      idx;

  logic [31:0]     shifted;
  logic [STEP-1:0] chunk;
  logic            chunk_hit;
  logic [4:0]      chunk_idx;
  logic            last;

  // Select the STEP-bit slice for this cycle and locate its highest set bit.
  // Ascending loop: the last hit is the highest bit within the slice.
  always_comb begin
    shifted   = cap << (STEP * int'(cnt));
    chunk     = shifted[31 -: STEP];
    chunk_hit = |chunk;
    chunk_idx = 5'd0;
    for (int i = 0; i < STEP; i++)
      if (chunk[i]) chunk_idx = 5'(32 - STEP * (int'(cnt) + 1) + i);
    last      = (cnt == CW'(N - 1));
  end

  // Control FSM, scan datapath and registered result outputs.
  // Slices are scanned high to low, so the first hit is the highest set bit;
  // later hits are ignored once found is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap       <= '0;
      found     <= 1'b0;
      idx       <= 5'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nonzero   <= 1'b0;
      zero      <= 1'b1;
      msb_index <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        SCAN: begin
          if (!found && chunk_hit) begin
            found <= 1'b1;
            idx   <= chunk_idx;
          end
          if (last) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            nonzero   <= found | chunk_hit;
            zero      <= ~(found | chunk_hit);
            msb_index <= found ? idx : (chunk_hit ? chunk_idx : 5'd0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // IDLE or DONE: not busy, so a start is accepted here.
          if (start) begin
            state <= SCAN;
            cap   <= in;
            cnt   <= '0;
            found <= 1'b0;
            idx   <= 5'd0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reduce_32bit.sv
// Bench for reduce_32bit: three instances (STEP 4, 1, 32) share stimulus.
// A cycle-level behavioural model (countdown of remaining busy cycles plus a
// plain highest-bit search) is compared against every instance each cycle,
// and directed operations pin latency and results with literal expectations.
module tb_reduce_32bit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] din = 32'd0;
  logic [2:0]  bsy, dn, nz, zr;
  logic [4:0]  mi [3];

  reduce_32bit #(.STEP(4)) u0 (
    .clk(clk), .reset(reset), .start(start), .in(din),
    .busy(bsy[0]), .done(dn[0]), .nonzero(nz[0]), .zero(zr[0]), .msb_index(mi[0])
  );
  reduce_32bit #(.STEP(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .in(din),
    .busy(bsy[1]), .done(dn[1]), .nonzero(nz[1]), .zero(zr[1]), .msb_index(mi[1])
  );
  reduce_32bit #(.STEP(32)) u2 (
    .clk(clk), .reset(reset), .start(start), .in(din),
    .busy(bsy[2]), .done(dn[2]), .nonzero(nz[2]), .zero(zr[2]), .msb_index(mi[2])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          ns [3] = '{8, 32, 1};
  int          rem [3];
  bit          mdone [3];
  bit          mnz [3];
  logic [4:0]  midx [3];
  logic [31:0] mw [3];

  function automatic logic [4:0] hb(input logic [31:0] w);
    hb = 5'd0;
    for (int i = 0; i < 32; i++) if (w[i]) hb = 5'(i);
  endfunction

  // Advance the model on each rising edge, then compare all instances.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      mdone[k] = 1'b0;
      if (reset) begin
        rem[k] = 0; mnz[k] = 1'b0; midx[k] = 5'd0;
      end else if (rem[k] > 0) begin
        rem[k]--;
        if (rem[k] == 0) begin
          mdone[k] = 1'b1;
          mnz[k]   = |mw[k];
          midx[k]  = hb(mw[k]);
        end
      end else if (start) begin
        mw[k]  = din;
        rem[k] = ns[k];
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy[%0d]", k),    32'(bsy[k]), 32'(rem[k] > 0));
      chk($sformatf("done[%0d]", k),    32'(dn[k]),  32'(mdone[k]));
      chk($sformatf("nonzero[%0d]", k), 32'(nz[k]),  32'(mnz[k]));
      chk($sformatf("zero[%0d]", k),    32'(zr[k]),  32'(!mnz[k]));
      chk($sformatf("msb[%0d]", k),     32'(mi[k]),  32'(midx[k]));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_op(input logic [31:0] w, input int k, input logic [4:0] eidx);
    int  c, bc;
    bit  got;
    @(negedge clk);
    reset = 1'b0; start = 1'b1; din = w;
    c = 0; bc = 0; got = 1'b0;
    while (c < 60 && !got) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) begin start = 1'b0; din = $urandom; end
      if (bsy[k]) bc++;
      if (dn[k]) got = 1'b1;
    end
    chk($sformatf("op_lat[%0d]", k),  32'(c),  32'(ns[k] + 1));
    chk($sformatf("op_busy[%0d]", k), 32'(bc), 32'(ns[k]));
    chk($sformatf("op_msb[%0d]", k),  32'(mi[k]), 32'(eidx));
    chk($sformatf("op_nz[%0d]", k),   32'(nz[k]), 32'(w != 0));
    chk($sformatf("op_zero[%0d]", k), 32'(zr[k]), 32'(w == 0));
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int  c;
    bit  got, seen;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_done", 32'(dn[0]),  32'd0);
    chk("rst_nz",   32'(nz[0]),  32'd0);
    chk("rst_zero", 32'(zr[0]),  32'd1);
    chk("rst_msb",  32'(mi[0]),  32'd0);

    // Start in the first cycle after reset release.
    run_op(32'h0000_0000, 0, 5'd0);
    run_op(32'h8000_0001, 0, 5'd31);
    run_op(32'h0000_0001, 0, 5'd0);

    // Start held high, in changes during the scan, then back-to-back op.
    @(negedge clk);
    start = 1'b1; din = 32'h0001_0000;
    c = 0; got = 1'b0;
    while (c < 40 && !got) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) din = 32'hFFFF_FFFF;
      if (dn[0]) got = 1'b1;
    end
    chk("hold_lat", 32'(c), 32'd9);
    chk("hold_msb", 32'(mi[0]), 32'd16);
    din = 32'h0000_0100;
    @(posedge clk); #1;
    chk("b2b_busy", 32'(bsy[0]), 32'd1);
    start = 1'b0; din = $urandom;
    c = 1; got = 1'b0;
    while (c < 40 && !got) begin
      @(posedge clk); #1;
      c++;
      if (dn[0]) got = 1'b1;
    end
    chk("b2b_lat", 32'(c), 32'd9);
    chk("b2b_msb", 32'(mi[0]), 32'd8);

    // Reset in the third scan cycle aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; din = 32'h0F00_0000;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(bsy[0]), 32'd0);
    chk("abort_done", 32'(dn[0]),  32'd0);
    chk("abort_nz",   32'(nz[0]),  32'd0);
    chk("abort_zero", 32'(zr[0]),  32'd1);
    chk("abort_msb",  32'(mi[0]),  32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (dn[0]) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    // Extreme STEP instances.
    idle(40);
    run_op(32'h0000_0400, 1, 5'd10);
    idle(40);
    run_op(32'h7FFF_FFFF, 2, 5'd30);

    // Randomized traffic, occasional reset.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: din = 32'd0;
        1: din = 32'd1 << $urandom_range(0, 31);
        2: din = $urandom >> $urandom_range(0, 31);
        default: din = $urandom;
      endcase
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
